result_writer: RTL and testbench

//  Burst-writes a block of MEM_DEPTH words from on-chip BRAM to DDR over AXI4 write channels (AW/W/B).

---
 rtl/tva_axi_pkg.sv | 19 +
 rtl/wr_prefetch_fifo.sv | 57 +++++
 rtl/result_writer.sv | 194 +++++++++++++++++++
 tb/tb_result_writer.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tva_axi_pkg.sv
// Shared AXI4 write-channel constants and the result-writer FSM state type.
package tva_axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AW   = 3'd1,
        W    = 3'd2,
        B    = 3'd3,
        DONE = 3'd4
    } wr_state_t;

endpackage

// File: rtl/wr_prefetch_fifo.sv
// Two-entry FIFO between the BRAM read port and the AXI W channel.
// It holds {last, data} so a beat survives wready backpressure while the
// next BRAM read is already on its way.
module wr_prefetch_fifo #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       cnt;
    logic             push_ok;
    logic             pop_ok;

    assign full      = (cnt == 2'd2);
    assign empty     = (cnt == 2'd0);
    assign count     = cnt;
    assign head_data = mem_q[rd_ptr];
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;

    // Storage, pointers and occupancy; everything clears on reset so the
    // head reads as zero while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            cnt      <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr] <= push_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/result_writer.sv
// Drains MEM_DEPTH words from BRAM to DDR as back-to-back AXI4 INCR bursts.
// One burst is outstanding at a time: AW, then all W beats, then the B
// response, repeated MEM_DEPTH/BURST_LEN times, then a one-cycle done.
//
// Handshakes: a transfer happens on a channel in exactly the cycle where
// both valid and ready are high; once valid is raised, the payload
// (awaddr, or wdata/wlast) and valid are held unchanged until that cycle,
// and valid never waits on ready.
module result_writer
    import tva_axi_pkg::*;
#(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    MEM_DEPTH       = 1024,
    parameter int                    BRAM_ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int                    BURST_LEN       = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       done,
    output logic                       busy,
    output logic                       err,
    output logic [ADDR_WIDTH-1:0]      awaddr,
    output logic [7:0]                 awlen,
    output logic [2:0]                 awsize,
    output logic [1:0]                 awburst,
    output logic                       awvalid,
    input  logic                       awready,
    output logic [DATA_WIDTH-1:0]      wdata,
    output logic [DATA_WIDTH/8-1:0]    wstrb,
    output logic                       wlast,
    output logic                       wvalid,
    input  logic                       wready,
    input  logic [1:0]                 bresp,
    input  logic                       bvalid,
    output logic                       bready,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
    output logic                       bram_en,
    input  logic [DATA_WIDTH-1:0]      bram_dout,
    output wr_state_t                  dbg_state
);

    localparam int                    BYTES_PER_BEAT = DATA_WIDTH / 8;
    localparam int                    NUM_BURSTS     = MEM_DEPTH / BURST_LEN;
    localparam int                    BURST_CNT_W    = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam int                    WORD_CNT_W     = BRAM_ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] BURST_BYTES    = ADDR_WIDTH'(BURST_LEN * BYTES_PER_BEAT);
    localparam logic [WORD_CNT_W-1:0] WORD_TOTAL     = WORD_CNT_W'(MEM_DEPTH);
    localparam logic [8:0]            LAST_BEAT      = 9'(BURST_LEN - 1);
    localparam logic [BURST_CNT_W-1:0] LAST_BURST    = BURST_CNT_W'(NUM_BURSTS - 1);

    wr_state_t               state;
    logic [WORD_CNT_W-1:0]   rd_cnt;
    logic [8:0]              rd_beat;
    logic                    rd_inflight;
    logic                    rd_last_q;
    logic [BURST_CNT_W-1:0]  burst_cnt;

    logic                    rd_issue;
    logic                    w_hs;
    logic [2:0]              occupancy;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [1:0]              fifo_count;
    logic [DATA_WIDTH:0]     fifo_head;

    assign dbg_state = state;
    assign awsize    = 3'($clog2(BYTES_PER_BEAT));
    assign awburst   = AXI_BURST_INCR;

    // Beats are only offered in W so prefetched data for the next burst
    // waits in the FIFO until its AW has been accepted.
    assign wvalid = (state == W) && !fifo_empty;
    assign wdata  = fifo_head[DATA_WIDTH-1:0];
    assign wlast  = wvalid && fifo_head[DATA_WIDTH];
    assign wstrb  = {BYTES_PER_BEAT{wvalid}};
    assign w_hs   = wvalid && wready;

    // A read is allowed when buffered plus in-flight words stay below two,
    // counting the beat leaving this cycle; that keeps 1 beat/cycle with
    // wready high and never overflows the two entries.
    assign occupancy = {1'b0, fifo_count} + {2'b00, rd_inflight};
    assign rd_issue  = ((state == AW) || (state == W) || (state == B))
                     && (rd_cnt < WORD_TOTAL)
                     && (!fifo_full || w_hs)
                     && ((occupancy < 3'd2) || ((occupancy == 3'd2) && w_hs));

    assign bram_en   = rd_issue;
    assign bram_addr = rd_cnt[BRAM_ADDR_WIDTH-1:0];

    wr_prefetch_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_inflight),
        .push_data ({rd_last_q, bram_dout}),
        .pop       (w_hs),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // BRAM read issue: word counter, position within the burst, and the
    // one-cycle in-flight marker that pushes bram_dout into the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt      <= '0;
            rd_beat     <= '0;
            rd_inflight <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            rd_inflight <= rd_issue;
            if ((state == IDLE) && start) begin
                rd_cnt  <= '0;
                rd_beat <= '0;
            end else if (rd_issue) begin
                rd_cnt    <= rd_cnt + 1'b1;
                rd_last_q <= (rd_beat == LAST_BEAT);
                rd_beat   <= (rd_beat == LAST_BEAT) ? 9'd0 : rd_beat + 9'd1;
            end
        end
    end

    // Control FSM with registered AW/B/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            awvalid   <= 1'b0;
            awaddr    <= '0;
            awlen     <= 8'd0;
            bready    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            burst_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= AW;
                        awvalid   <= 1'b1;
                        awaddr    <= BASE_ADDR;
                        awlen     <= 8'(BURST_LEN - 1);
                        busy      <= 1'b1;
                        err       <= 1'b0;
                        burst_cnt <= '0;
                    end
                end
                AW: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                        state   <= W;
                    end
                end
                W: begin
                    if (w_hs && wlast) begin
                        bready <= 1'b1;
                        state  <= B;
                    end
                end
                B: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        if (bresp != AXI_RESP_OKAY) begin
                            err <= 1'b1;
                        end
                        if (burst_cnt == LAST_BURST) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            burst_cnt <= burst_cnt + 1'b1;
                            awaddr    <= awaddr + BURST_BYTES;
                            awvalid   <= 1'b1;
                            state     <= AW;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_writer.sv
// Bench for result_writer: a reactive AXI slave and BRAM model drive the
// DUT, the expected AW addresses and W beats of each run are queued when
// its start is accepted, and a negedge monitor checks every handshake.
module tb_result_writer;
    import tva_axi_pkg::*;

    localparam int          AWID  = 32;
    localparam int          DW    = 32;
    localparam int          DEPTH = 32;
    localparam int          BLEN  = 16;
    localparam int          BAW   = 5;
    localparam int          NB    = DEPTH / BLEN;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            done, busy, err;
    logic [AWID-1:0] awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awvalid, awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast, wvalid, wready;
    logic [1:0]      bresp;
    logic            bvalid, bready;
    logic [BAW-1:0]  bram_addr;
    logic            bram_en;
    logic [DW-1:0]   bram_dout;
    wr_state_t       dbg_state;

    always #5 clk = ~clk;

    result_writer #(
        .ADDR_WIDTH (AWID),
        .DATA_WIDTH (DW),
        .MEM_DEPTH  (DEPTH),
        .BURST_LEN  (BLEN),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .done      (done),
        .busy      (busy),
        .err       (err),
        .awaddr    (awaddr),
        .awlen     (awlen),
        .awsize    (awsize),
        .awburst   (awburst),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wlast     (wlast),
        .wvalid    (wvalid),
        .wready    (wready),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready),
        .bram_addr (bram_addr),
        .bram_en   (bram_en),
        .bram_dout (bram_dout),
        .dbg_state (dbg_state)
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0]   mem [DEPTH];
    logic [DW:0]     exp_q[$];
    logic [AWID-1:0] exp_aw_q[$];

    int         aw_stall_cycles = 0;
    bit         w_rand          = 1'b0;
    logic [1:0] bresp_tab [NB];

    int             aw_wait   = 0;
    int             b_pend    = 0;
    int             b_idx     = 0;
    bit             b_hs_seen = 1'b0;
    bit             rd_req    = 1'b0;
    logic [BAW-1:0] rd_addr_q = '0;

    bit in_reset  = 1'b1;
    bit tb_idle   = 1'b1;
    bit err_model = 1'b0;
    int exp_rd    = 0;
    int aw_hs_cnt = 0;
    int wlast_cnt = 0;
    int b_hs_cnt  = 0;
    int beats_run = 0;
    int done_cnt  = 0;
    int aw_total  = 0;

    bit              aw_stall_prev = 1'b0;
    logic [AWID-1:0] awaddr_prev   = '0;
    bit              w_stall_prev  = 1'b0;
    logic [DW-1:0]   wdata_prev    = '0;
    logic            wlast_prev    = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: event not allowed here", name);
    endtask

    task automatic clear_model();
        exp_q.delete();
        exp_aw_q.delete();
        tb_idle       = 1'b1;
        err_model     = 1'b0;
        exp_rd        = 0;
        aw_hs_cnt     = 0;
        wlast_cnt     = 0;
        b_hs_cnt      = 0;
        beats_run     = 0;
        aw_wait       = 0;
        b_pend        = 0;
        b_idx         = 0;
        b_hs_seen     = 1'b0;
        rd_req        = 1'b0;
        aw_stall_prev = 1'b0;
        w_stall_prev  = 1'b0;
    endtask

    // Reference model of one run: every word in address order, last flag on
    // each BLEN-th beat, one burst address per BLEN words.
    task automatic push_run_expectations();
        logic [DW:0] beat;
        for (int i = 0; i < DEPTH; i++) begin
            beat = {((i % BLEN) == BLEN - 1) ? 1'b1 : 1'b0, mem[i]};
            exp_q.push_back(beat);
        end
        for (int k = 0; k < NB; k++) begin
            exp_aw_q.push_back(BASE + AWID'(k * BLEN * (DW / 8)));
        end
    endtask

    task automatic monitor_cycle();
        logic [DW:0] e;
        chk("busy", busy, !tb_idle);
        chk("err", err, err_model);
        if (aw_stall_prev) begin
            chk("aw_hold_valid", awvalid, 1);
            chk("aw_hold_addr", awaddr, awaddr_prev);
        end
        if (w_stall_prev) begin
            chk("w_hold_valid", wvalid, 1);
            chk("w_hold_data", wdata, wdata_prev);
            chk("w_hold_last", wlast, wlast_prev);
        end
        if (wvalid && wready) begin
            chk("w_after_aw", aw_hs_cnt > wlast_cnt, 1);
            chk("wstrb", wstrb, {(DW/8){1'b1}});
            if (exp_q.size() == 0) begin
                fail_now("w_extra_beat");
            end else begin
                e = exp_q.pop_front();
                chk("wdata", wdata, e[DW-1:0]);
                chk("wlast", wlast, e[DW]);
            end
            beats_run++;
            if (wlast) begin
                wlast_cnt++;
                b_pend++;
            end
        end
        if (awvalid && awready) begin
            chk("aw_one_outstanding", aw_hs_cnt, b_hs_cnt);
            if (exp_aw_q.size() == 0) begin
                fail_now("aw_extra");
            end else begin
                chk("awaddr", awaddr, exp_aw_q.pop_front());
            end
            chk("awlen", awlen, BLEN - 1);
            chk("awsize", awsize, 2);
            chk("awburst", awburst, 1);
            aw_hs_cnt++;
            aw_total++;
            aw_wait = 0;
        end else if (awvalid) begin
            aw_wait++;
        end
        if (bram_en) begin
            chk("bram_addr", bram_addr, exp_rd);
            chk("bram_in_range", exp_rd < DEPTH, 1);
            exp_rd++;
        end
        rd_req    = bram_en;
        rd_addr_q = bram_addr;
        if (bvalid && bready) begin
            b_hs_seen = 1'b1;
            b_hs_cnt++;
            if (bresp != 2'b00) err_model = 1'b1;
        end
        if (tb_idle && start) begin
            push_run_expectations();
            tb_idle   = 1'b0;
            err_model = 1'b0;
            exp_rd    = 0;
            aw_hs_cnt = 0;
            wlast_cnt = 0;
            b_hs_cnt  = 0;
            beats_run = 0;
            b_idx     = 0;
        end else if (done) begin
            if (tb_idle) begin
                fail_now("done_unexpected");
            end else begin
                chk("done_w_drained", exp_q.size(), 0);
                chk("done_aw_drained", exp_aw_q.size(), 0);
                chk("done_reads", exp_rd, DEPTH);
                chk("done_beats", beats_run, DEPTH);
                chk("done_bursts", b_hs_cnt, NB);
                tb_idle = 1'b1;
                done_cnt++;
            end
        end
        aw_stall_prev = awvalid && !awready;
        awaddr_prev   = awaddr;
        w_stall_prev  = wvalid && !wready;
        wdata_prev    = wdata;
        wlast_prev    = wlast;
    endtask

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!in_reset) monitor_cycle();
        end
    end

    // AXI slave and BRAM responder.
    initial begin
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        bresp     = 2'b00;
        bram_dout = '0;
        forever begin
            @(posedge clk);
            #1;
            if (in_reset) begin
                awready = 1'b0;
                wready  = 1'b0;
                bvalid  = 1'b0;
                bresp   = 2'b00;
            end else begin
                if (rd_req) bram_dout = mem[rd_addr_q];
                awready = (aw_wait >= aw_stall_cycles);
                wready  = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                if (b_hs_seen) begin
                    b_hs_seen = 1'b0;
                    bvalid    = 1'b0;
                    bresp     = 2'b00;
                    b_pend--;
                    b_idx++;
                end
                if (!bvalid && b_pend > 0) begin
                    bvalid = 1'b1;
                    bresp  = bresp_tab[b_idx % NB];
                end
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_awaddr"}, awaddr, 0);
        chk({tag, "_awlen"}, awlen, 0);
        chk({tag, "_awvalid"}, awvalid, 0);
        chk({tag, "_awsize"}, awsize, 2);
        chk({tag, "_awburst"}, awburst, 1);
        chk({tag, "_wdata"}, wdata, 0);
        chk({tag, "_wstrb"}, wstrb, 0);
        chk({tag, "_wlast"}, wlast, 0);
        chk({tag, "_wvalid"}, wvalid, 0);
        chk({tag, "_bready"}, bready, 0);
        chk({tag, "_bram_en"}, bram_en, 0);
        chk({tag, "_bram_addr"}, bram_addr, 0);
        chk({tag, "_state"}, dbg_state, IDLE);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int seen;
        int n;
        seen = done_cnt;
        n    = 0;
        while (done_cnt == seen && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == seen) fail_now("done_timeout");
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    endtask

    task automatic run_one();
        int d0;
        d0 = done_cnt;
        pulse_start();
        wait_done(400);
        chk("run_done_count", done_cnt - d0, 1);
        repeat (3) @(posedge clk);
    endtask

    // Stimulus sequence.
    initial begin
        int aw0;
        int d0;
        int n;
        rst   = 1'b1;
        start = 1'b0;
        for (int k = 0; k < NB; k++) bresp_tab[k] = 2'b00;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        clear_model();
        @(negedge clk);
        check_idle_outputs("reset");
        in_reset = 1'b0;

        // Ramp data, everything always ready.
        aw0 = aw_total;
        run_one();
        chk("t1_aw_count", aw_total - aw0, NB);

        // AW stalled five cycles per burst.
        fill_random();
        aw_stall_cycles = 5;
        aw0 = aw_total;
        run_one();
        chk("t2_aw_count", aw_total - aw0, NB);
        aw_stall_cycles = 0;

        // Random W backpressure.
        w_rand = 1'b1;
        for (int r = 0; r < 3; r++) begin
            fill_random();
            run_one();
        end
        w_rand = 1'b0;

        // SLVERR on the first burst only, then a clean run clears err.
        fill_random();
        bresp_tab[0] = 2'b10;
        run_one();
        chk("t4_err_sticky", err, 1);
        bresp_tab[0] = 2'b00;
        pulse_start();
        @(negedge clk);
        chk("t4_err_cleared", err, 0);
        wait_done(400);
        repeat (3) @(posedge clk);

        // Reset in the middle of beat 7 of burst 0.
        fill_random();
        pulse_start();
        n = 0;
        while (beats_run < 7 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (beats_run < 7) fail_now("t5_beat7_timeout");
        #2;
        in_reset = 1'b1;
        rst      = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        clear_model();
        @(negedge clk);
        check_idle_outputs("midrst");
        in_reset = 1'b0;
        fill_random();
        run_one();

        // Start held high across two full runs.
        fill_random();
        aw0 = aw_total;
        d0  = done_cnt;
        @(posedge clk);
        #2 start = 1'b1;
        wait_done(400);
        wait_done(400);
        #2 start = 1'b0;
        repeat (20) @(posedge clk);
        chk("t6_aw_count", aw_total - aw0, 2 * NB);
        chk("t6_done_count", done_cnt - d0, 2);
        chk("t6_idle_after", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
